// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared opcode, control-code and immediate helpers for decode_stage
package decode_stage_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_NONE   = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_SLL    = 5'd3,
    ALU_SLT    = 5'd4,
    ALU_SLTU   = 5'd5,
    ALU_XOR    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_OR     = 5'd9,
    ALU_AND    = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_SRC_NONE     = 3'd0,
    ALU_SRC_RS2      = 3'd1,
    ALU_SRC_IMM      = 3'd2,
    ALU_SRC_PC_IMM   = 3'd3,
    ALU_SRC_ZERO_IMM = 3'd4
  } alu_src_e;

  // Branches compare through the ALU and jump on a zero / non-zero result.
  typedef enum logic [2:0] {
    JUMP_NONE     = 3'd0,
    JUMP_IF_0     = 3'd1,
    JUMP_IF_NOT_0 = 3'd2,
    JUMP_ALWAYS   = 3'd3,
    JUMP_REG      = 3'd4
  } jump_type_e;

  typedef enum logic [1:0] {
    REG_SRC_NONE = 2'd0,
    REG_SRC_ALU  = 2'd1,
    REG_SRC_MEM  = 2'd2,
    REG_SRC_PC4  = 2'd3
  } reg_src_e;

  typedef enum logic [2:0] {
    MEM_RD_NONE = 3'd0,
    MEM_RD_B    = 3'd1,
    MEM_RD_H    = 3'd2,
    MEM_RD_W    = 3'd3,
    MEM_RD_BU   = 3'd4,
    MEM_RD_HU   = 3'd5
  } mem_rd_e;

  typedef enum logic [3:0] {
    MEM_WR_NONE = 4'b0000,
    MEM_WR_B    = 4'b0001,
    MEM_WR_H    = 4'b0011,
    MEM_WR_W    = 4'b1111
  } mem_wr_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    alu_src_e    alu_src;
    jump_type_e  jump_type;
    reg_src_e    regfile_src;
    mem_rd_e     mem_read_type;
    mem_wr_e     mem_write_mask;
    logic        reg_write;
    logic        illegal;
  } decode_bundle_t;

  localparam int DEC_W = $bits(decode_bundle_t);

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'h000};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic alu_op_e alu_base(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_logic.sv
// rtl/decode_logic.sv - combinational RV32I/RV32M instruction decoder
module decode_logic
  import decode_stage_pkg::*;
#(
  parameter int EN_M = 1
) (
  input  logic [31:0]      instr_i,
  output logic [DEC_W-1:0] bundle_o
);

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  logic           illegal;
  logic           writes_rd;
  decode_bundle_t ctl;
  decode_bundle_t dec;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    ctl       = '0;
    illegal   = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src     = ALU_SRC_ZERO_IMM;
        ctl.regfile_src = REG_SRC_ALU;
        ctl.imm         = imm_u(instr_i);
        writes_rd       = 1'b1;
      end
      OPC_AUIPC: begin
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src     = ALU_SRC_PC_IMM;
        ctl.regfile_src = REG_SRC_ALU;
        ctl.imm         = imm_u(instr_i);
        writes_rd       = 1'b1;
      end
      OPC_JAL: begin
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src     = ALU_SRC_PC_IMM;
        ctl.jump_type   = JUMP_ALWAYS;
        ctl.regfile_src = REG_SRC_PC4;
        ctl.imm         = imm_j(instr_i);
        writes_rd       = 1'b1;
      end
      OPC_JALR: begin
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src     = ALU_SRC_IMM;
        ctl.jump_type   = JUMP_REG;
        ctl.regfile_src = REG_SRC_PC4;
        ctl.imm         = imm_i(instr_i);
        writes_rd       = 1'b1;
        illegal         = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctl.alu_src = ALU_SRC_RS2;
        ctl.imm     = imm_b(instr_i);
        case (funct3)
          3'b000:  begin ctl.alu_op = ALU_XOR;  ctl.jump_type = JUMP_IF_0;     end
          3'b001:  begin ctl.alu_op = ALU_XOR;  ctl.jump_type = JUMP_IF_NOT_0; end
          3'b100:  begin ctl.alu_op = ALU_SLT;  ctl.jump_type = JUMP_IF_NOT_0; end
          3'b101:  begin ctl.alu_op = ALU_SLT;  ctl.jump_type = JUMP_IF_0;     end
          3'b110:  begin ctl.alu_op = ALU_SLTU; ctl.jump_type = JUMP_IF_NOT_0; end
          3'b111:  begin ctl.alu_op = ALU_SLTU; ctl.jump_type = JUMP_IF_0;     end
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctl.alu_op      = ALU_ADD;
        ctl.alu_src     = ALU_SRC_IMM;
        ctl.regfile_src = REG_SRC_MEM;
        ctl.imm         = imm_i(instr_i);
        writes_rd       = 1'b1;
        case (funct3)
          3'b000:  ctl.mem_read_type = MEM_RD_B;
          3'b001:  ctl.mem_read_type = MEM_RD_H;
          3'b010:  ctl.mem_read_type = MEM_RD_W;
          3'b100:  ctl.mem_read_type = MEM_RD_BU;
          3'b101:  ctl.mem_read_type = MEM_RD_HU;
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctl.alu_op  = ALU_ADD;
        ctl.alu_src = ALU_SRC_IMM;
        ctl.imm     = imm_s(instr_i);
        case (funct3)
          3'b000:  ctl.mem_write_mask = MEM_WR_B;
          3'b001:  ctl.mem_write_mask = MEM_WR_H;
          3'b010:  ctl.mem_write_mask = MEM_WR_W;
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        ctl.alu_op      = alu_base(funct3);
        ctl.alu_src     = ALU_SRC_IMM;
        ctl.regfile_src = REG_SRC_ALU;
        ctl.imm         = imm_i(instr_i);
        writes_rd       = 1'b1;
        // Shift-immediates reuse the funct7 slot of the I immediate as an opcode extension.
        if (funct3 == 3'b001) begin
          illegal = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) ctl.alu_op = ALU_SRA;
          else if (funct7 != 7'b0000000) illegal = 1'b1;
        end
      end
      OPC_OP: begin
        ctl.alu_src     = ALU_SRC_RS2;
        ctl.regfile_src = REG_SRC_ALU;
        writes_rd       = 1'b1;
        if (funct7 == 7'b0000000) begin
          ctl.alu_op = alu_base(funct3);
        end else if (funct7 == 7'b0100000) begin
          case (funct3)
            3'b000:  ctl.alu_op = ALU_SUB;
            3'b101:  ctl.alu_op = ALU_SRA;
            default: illegal = 1'b1;
          endcase
        end else if (funct7 == 7'b0000001 && EN_M != 0) begin
          case (funct3)
            3'b000:  ctl.alu_op = ALU_MUL;
            3'b001:  ctl.alu_op = ALU_MULH;
            3'b010:  ctl.alu_op = ALU_MULHSU;
            3'b011:  ctl.alu_op = ALU_MULHU;
            3'b100:  ctl.alu_op = ALU_DIV;
            3'b101:  ctl.alu_op = ALU_DIVU;
            3'b110:  ctl.alu_op = ALU_REM;
            default: ctl.alu_op = ALU_REMU;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal entries still travel down the pipe, but with every control field neutralised.
  always_comb begin
    if (illegal) dec = '0;
    else         dec = ctl;
    dec.rs1       = instr_i[19:15];
    dec.rs2       = instr_i[24:20];
    dec.rd        = instr_i[11:7];
    dec.reg_write = writes_rd && !illegal && (instr_i[11:7] != 5'd0);
    dec.illegal   = illegal;
  end

  assign bundle_o = dec;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: combinational decode into a 1- or 2-entry output buffer
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int EN_M  = 1,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_alu_op,
  output logic [2:0]      out_alu_src,
  output logic [2:0]      out_jump_type,
  output logic [1:0]      out_regfile_src,
  output logic [2:0]      out_mem_read_type,
  output logic [3:0]      out_mem_write_mask,
  output logic            out_reg_write,
  output logic            out_illegal
);

  decode_bundle_t  dec_w;
  decode_bundle_t  ent0_q, ent0_d, ent1_q, ent1_d;
  logic [PC_W-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [1:0]      count_q, count_d;
  logic            push, pop;

  decode_logic #(.EN_M(EN_M)) u_decode_logic (
    .instr_i  (in_instr),
    .bundle_o (dec_w)
  );

  assign out_valid = (count_q != 2'd0);

  // The skid variant decides readiness from occupancy alone so out_ready never reaches in_ready.
  generate
    if (DEPTH == 1) begin : g_single
      assign in_ready = !flush && (!out_valid || out_ready);
    end else begin : g_skid
      assign in_ready = !flush && (count_q < 2'd2);
    end
  endgenerate

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready && !flush;

  // Entry 0 is always the oldest; entry 1 only holds data when two are buffered.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    pc0_d   = pc0_q;
    pc1_d   = pc1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_d = dec_w;
            pc0_d  = in_pc;
          end else begin
            ent1_d = dec_w;
            pc1_d  = in_pc;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          pc0_d   = pc1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = dec_w;
            pc0_d  = in_pc;
          end else begin
            ent0_d = ent1_q;
            pc0_d  = pc1_q;
            ent1_d = dec_w;
            pc1_d  = in_pc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      ent0_q  <= '0;
      ent1_q  <= '0;
      pc0_q   <= '0;
      pc1_q   <= '0;
    end else begin
      count_q <= count_d;
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      pc0_q   <= pc0_d;
      pc1_q   <= pc1_d;
    end
  end

  assign out_pc             = pc0_q;
  assign out_rs1            = ent0_q.rs1;
  assign out_rs2            = ent0_q.rs2;
  assign out_rd             = ent0_q.rd;
  assign out_imm            = ent0_q.imm;
  assign out_alu_op         = ent0_q.alu_op;
  assign out_alu_src        = ent0_q.alu_src;
  assign out_jump_type      = ent0_q.jump_type;
  assign out_regfile_src    = ent0_q.regfile_src;
  assign out_mem_read_type  = ent0_q.mem_read_type;
  assign out_mem_write_mask = ent0_q.mem_write_mask;
  assign out_reg_write      = ent0_q.reg_write;
  assign out_illegal        = ent0_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_instr, a_in_pc, a_out_pc, a_out_imm;
  logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd, a_out_alu_op;
  logic [2:0]  a_out_alu_src, a_out_jump_type, a_out_mem_read_type;
  logic [1:0]  a_out_regfile_src;
  logic [3:0]  a_out_mem_write_mask;
  logic        a_out_reg_write, a_out_illegal;
  logic [19:0] a_ctl;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_instr, b_in_pc, b_out_pc, b_out_imm;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd, b_out_alu_op;
  logic [2:0]  b_out_alu_src, b_out_jump_type, b_out_mem_read_type;
  logic [1:0]  b_out_regfile_src;
  logic [3:0]  b_out_mem_write_mask;
  logic        b_out_reg_write, b_out_illegal;

  assign a_ctl = {a_out_alu_op, a_out_alu_src, a_out_jump_type,
                  a_out_regfile_src, a_out_mem_read_type, a_out_mem_write_mask};

  decode_stage #(.DEPTH(2), .EN_M(1), .PC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd), .out_imm(a_out_imm),
    .out_alu_op(a_out_alu_op), .out_alu_src(a_out_alu_src), .out_jump_type(a_out_jump_type),
    .out_regfile_src(a_out_regfile_src), .out_mem_read_type(a_out_mem_read_type),
    .out_mem_write_mask(a_out_mem_write_mask), .out_reg_write(a_out_reg_write),
    .out_illegal(a_out_illegal)
  );

  decode_stage #(.DEPTH(1), .EN_M(0), .PC_W(32)) u_dut_nom (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_imm(b_out_imm),
    .out_alu_op(b_out_alu_op), .out_alu_src(b_out_alu_src), .out_jump_type(b_out_jump_type),
    .out_regfile_src(b_out_regfile_src), .out_mem_read_type(b_out_mem_read_type),
    .out_mem_write_mask(b_out_mem_write_mask), .out_reg_write(b_out_reg_write),
    .out_illegal(b_out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic        rw;
    logic [31:0] imm;
    logic [19:0] ctl;
  } vec_t;

  function automatic logic [19:0] mk_ctl(input logic [4:0] alu, input logic [2:0] src,
                                         input logic [2:0] jmp, input logic [1:0] rsrc,
                                         input logic [2:0] mrd, input logic [3:0] mwr);
    return {alu, src, jmp, rsrc, mrd, mwr};
  endfunction

  task automatic push_a(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    a_in_valid = 1'b1; a_in_instr = instr; a_in_pc = pc;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic pop_a();
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_out_illegal !== 1'b0 || a_out_reg_write !== 1'b0) begin
      bad++; $display("FAIL reset_flags got v=%b i=%b rw=%b want 0 0 0", a_out_valid, a_out_illegal, a_out_reg_write);
    end
    total++;
    if (a_out_pc !== 32'h0 || a_out_imm !== 32'h0 || a_ctl !== 20'h0 || a_out_rd !== 5'd0) begin
      bad++; $display("FAIL reset_fields got pc=%h imm=%h ctl=%h rd=%h want 0", a_out_pc, a_out_imm, a_ctl, a_out_rd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got a=%b b=%b want 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_add_fields();
    a_out_ready = 1'b0;
    push_a(32'h002081B3, 32'h100);
    total++;
    if (a_out_valid !== 1'b1 || a_out_pc !== 32'h100) begin
      bad++; $display("FAIL add_valid got v=%b pc=%h want 1 00000100", a_out_valid, a_out_pc);
    end
    total++;
    if ({a_out_rs1, a_out_rs2, a_out_rd} !== {5'd1, 5'd2, 5'd3}) begin
      bad++; $display("FAIL add_regs got %0d %0d %0d want 1 2 3", a_out_rs1, a_out_rs2, a_out_rd);
    end
    pop_a();
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL add_pop got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_decode_table();
    vec_t v[$];
    v.push_back('{32'h002081B3, 1'b0, 1'b1, 32'h0,
                  mk_ctl(ALU_ADD, ALU_SRC_RS2, JUMP_NONE, REG_SRC_ALU, MEM_RD_NONE, MEM_WR_NONE)});
    v.push_back('{32'h027302B3, 1'b0, 1'b1, 32'h0,
                  mk_ctl(ALU_MUL, ALU_SRC_RS2, JUMP_NONE, REG_SRC_ALU, MEM_RD_NONE, MEM_WR_NONE)});
    v.push_back('{32'hFE000EE3, 1'b0, 1'b0, 32'hFFFFFFFC,
                  mk_ctl(ALU_XOR, ALU_SRC_RS2, JUMP_IF_0, REG_SRC_NONE, MEM_RD_NONE, MEM_WR_NONE)});
    v.push_back('{32'h0000B003, 1'b1, 1'b0, 32'h0, 20'h0});
    v.push_back('{32'h0000A083, 1'b0, 1'b1, 32'h0,
                  mk_ctl(ALU_ADD, ALU_SRC_IMM, JUMP_NONE, REG_SRC_MEM, MEM_RD_W, MEM_WR_NONE)});
    v.push_back('{32'h0020A223, 1'b0, 1'b0, 32'h4,
                  mk_ctl(ALU_ADD, ALU_SRC_IMM, JUMP_NONE, REG_SRC_NONE, MEM_RD_NONE, MEM_WR_W)});
    v.push_back('{32'h123450B7, 1'b0, 1'b1, 32'h12345000,
                  mk_ctl(ALU_ADD, ALU_SRC_ZERO_IMM, JUMP_NONE, REG_SRC_ALU, MEM_RD_NONE, MEM_WR_NONE)});
    v.push_back('{32'h00100013, 1'b0, 1'b0, 32'h1,
                  mk_ctl(ALU_ADD, ALU_SRC_IMM, JUMP_NONE, REG_SRC_ALU, MEM_RD_NONE, MEM_WR_NONE)});
    v.push_back('{32'h4030D093, 1'b0, 1'b1, 32'h403,
                  mk_ctl(ALU_SRA, ALU_SRC_IMM, JUMP_NONE, REG_SRC_ALU, MEM_RD_NONE, MEM_WR_NONE)});
    v.push_back('{32'hFF9FF0EF, 1'b0, 1'b1, 32'hFFFFFFF8,
                  mk_ctl(ALU_ADD, ALU_SRC_PC_IMM, JUMP_ALWAYS, REG_SRC_PC4, MEM_RD_NONE, MEM_WR_NONE)});
    v.push_back('{32'h40109093, 1'b1, 1'b0, 32'h0, 20'h0});
    v.push_back('{32'h000090E7, 1'b1, 1'b0, 32'h0, 20'h0});
    v.push_back('{32'h0000007F, 1'b1, 1'b0, 32'h0, 20'h0});
    v.push_back('{32'h401090B3, 1'b1, 1'b0, 32'h0, 20'h0});
    a_out_ready = 1'b0;
    foreach (v[i]) begin
      push_a(v[i].instr, 32'h200 + 32'(i) * 4);
      total++;
      if (a_out_valid !== 1'b1 || a_out_illegal !== v[i].ill || a_out_reg_write !== v[i].rw) begin
        bad++; $display("FAIL dec_flags[%h] got v=%b ill=%b rw=%b want 1 %b %b",
                        v[i].instr, a_out_valid, a_out_illegal, a_out_reg_write, v[i].ill, v[i].rw);
      end
      total++;
      if (a_out_imm !== v[i].imm || a_ctl !== v[i].ctl) begin
        bad++; $display("FAIL dec_fields[%h] got imm=%h ctl=%h want imm=%h ctl=%h",
                        v[i].instr, a_out_imm, a_ctl, v[i].imm, v[i].ctl);
      end
      pop_a();
    end
  endtask

  task automatic test_no_m_single();
    b_out_ready = 1'b0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_instr = 32'h027302B3; b_in_pc = 32'h300;
    total++;
    if (b_in_ready !== 1'b1) begin
      bad++; $display("FAIL nom_ready_empty got %b want 1", b_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    total++;
    if (b_out_valid !== 1'b1 || b_out_illegal !== 1'b1 || b_out_reg_write !== 1'b0 || b_out_alu_op !== 5'd0) begin
      bad++; $display("FAIL nom_mul got v=%b ill=%b rw=%b alu=%0d want 1 1 0 0",
                      b_out_valid, b_out_illegal, b_out_reg_write, b_out_alu_op);
    end
    total++;
    if (b_in_ready !== 1'b0) begin
      bad++; $display("FAIL single_full_ready got %b want 0", b_in_ready);
    end
    b_out_ready = 1'b1;
    #1;
    total++;
    if (b_in_ready !== 1'b1) begin
      bad++; $display("FAIL single_passthru_ready got %b want 1", b_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    b_out_ready = 1'b0;
    total++;
    if (b_out_valid !== 1'b0) begin
      bad++; $display("FAIL single_drain got v=%b want 0", b_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    logic        accepted;
    a_out_ready = 1'b0;
    @(negedge clk);
    a_in_valid = 1'b1; a_in_instr = 32'h002081B3; a_in_pc = 32'h10;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready0 got %b want 1", a_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_in_pc = 32'h14;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready1 got %b want 1", a_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    a_in_pc = 32'h18;
    total++;
    if (a_in_ready !== 1'b0 || a_out_pc !== 32'h10) begin
      bad++; $display("FAIL b2b_full got rdy=%b pc=%h want 0 00000010", a_in_ready, a_out_pc);
    end
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b0 || a_out_pc !== 32'h10) begin
      bad++; $display("FAIL b2b_hold got rdy=%b pc=%h want 0 00000010", a_in_ready, a_out_pc);
    end
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (a_out_valid && a_out_ready) got.push_back(a_out_pc);
      accepted = a_in_valid && a_in_ready;
      @(posedge clk);
      @(negedge clk);
      if (accepted) a_in_valid = 1'b0;
    end
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    total++;
    if (got.size() != 3) begin
      bad++; $display("FAIL b2b_count got %0d want 3", got.size());
    end else begin
      total++;
      if (got[0] !== 32'h10 || got[1] !== 32'h14 || got[2] !== 32'h18) begin
        bad++; $display("FAIL b2b_order got %h %h %h want 10 14 18", got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    a_out_ready = 1'b0;
    push_a(32'h002081B3, 32'h20);
    push_a(32'h002081B3, 32'h24);
    a_flush = 1'b1; a_in_valid = 1'b1; a_in_instr = 32'h027302B3; a_in_pc = 32'h28;
    #1;
    total++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_pre got rdy=%b v=%b want 0 1", a_in_ready, a_out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_empty got v=%b want 0", a_out_valid);
    end
    a_out_ready = 1'b1;
    seen = 0;
    repeat (3) begin
      if (a_out_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    a_out_ready = 1'b0;
    total++;
    if (seen != 0 || a_in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_ghost got seen=%0d rdy=%b want 0 1", seen, a_in_ready);
    end
  endtask

  task automatic test_mid_reset();
    a_out_ready = 1'b0;
    push_a(32'h0000B003, 32'h44);
    push_a(32'h002081B3, 32'h48);
    total++;
    if (a_out_illegal !== 1'b1 || a_out_pc !== 32'h44) begin
      bad++; $display("FAIL mrst_pre got ill=%b pc=%h want 1 00000044", a_out_illegal, a_out_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_out_illegal !== 1'b0 || a_out_pc !== 32'h0 || a_ctl !== 20'h0) begin
      bad++; $display("FAIL mrst_async got v=%b ill=%b pc=%h ctl=%h want 0 0 0 0",
                      a_out_valid, a_out_illegal, a_out_pc, a_ctl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      bad++; $display("FAIL mrst_release got rdy=%b v=%b want 1 0", a_in_ready, a_out_valid);
    end
  endtask

  initial begin
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_in_pc = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_in_pc = '0; b_out_ready = 1'b0;
    test_reset();
    test_add_fields();
    test_decode_table();
    test_no_m_single();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
